game_timebase: RTL and testbench

Parametrised timebase and multi-channel game timer. A prescaler divides the system clock into a one-cycle `tick` at `TICK_HZ`. A wrapping elapsed-tick counter and `NUM_CH` independent countdown channels run from that tick. Game logic uses the channels for round timers, spawn intervals and cooldowns, and uses `tick`/`elapsed` as the shared frame-rate time reference.

---
 rtl/game_timer_pkg.sv | 16 +
 rtl/timer_channel.sv | 78 +++++++
 rtl/game_timebase.sv | 98 +++++++++
 tb/tb_game_timebase.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_timer_pkg.sv
// Shared types and helpers for the game timebase.
// Holds the channel state encoding and the prescaler divide calculation.
package game_timer_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2,
      DONE   = 2'd3
   } ch_state_t;

   function automatic int calc_div(input int clk_hz, input int tick_hz);
      return clk_hz / tick_hz;
   endfunction

endpackage

// File: rtl/timer_channel.sv
// One countdown channel: FSM, remaining count and reload value.
// Command priority is load > pause > start > tick.
module timer_channel
   import game_timer_pkg::*;
#(
   parameter int CNT_W = 20
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             tick,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             start,
   input  logic             pause,
   input  logic             periodic,
   output logic [CNT_W-1:0] count,
   output logic             running,
   output logic             expire
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   ch_state_t        state;
   ch_state_t        state_nxt;
   logic [CNT_W-1:0] reload;
   logic [CNT_W-1:0] count_nxt;
   logic [CNT_W-1:0] reload_nxt;
   logic             expire_nxt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         count  <= '0;
         reload <= '0;
         expire <= 1'b0;
      end else begin
         state  <= state_nxt;
         count  <= count_nxt;
         reload <= reload_nxt;
         expire <= expire_nxt;
      end
   end

   // A start in RUN falls through so a coincident tick still counts down
   always_comb begin
      state_nxt  = state;
      count_nxt  = count;
      reload_nxt = reload;
      expire_nxt = 1'b0;
      if (load) begin
         count_nxt  = load_val;
         reload_nxt = load_val;
         state_nxt  = IDLE;
      end else if (pause) begin
         if (state == RUN) state_nxt = PAUSED;
      end else if (start && (state != RUN)) begin
         if (count != '0) state_nxt = RUN;
      end else if (tick && (state == RUN)) begin
         if (count > ONE) begin
            count_nxt = count - ONE;
         end else if (count == ONE) begin
            expire_nxt = 1'b1;
            if (periodic) begin
               count_nxt = reload;
            end else begin
               count_nxt = '0;
               state_nxt = DONE;
            end
         end
      end
   end

   always_comb begin
      running = (state == RUN);
   end

endmodule

// File: rtl/game_timebase.sv
// Prescaled tick, wrapping elapsed-tick counter and NUM_CH countdown channels.
// All outputs are registered.
module game_timebase
   import game_timer_pkg::*;
#(
   parameter int     CLK_HZ  = 50_000_000,
   parameter int     TICK_HZ = 100,
   parameter int     CNT_W   = 20,
   parameter longint WRAP    = 1_000_000,
   parameter int     NUM_CH  = 4
)
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    tick_en,
   input  logic                    elapsed_clr,
   output logic                    tick,
   output logic [CNT_W-1:0]        elapsed,
   input  logic [NUM_CH-1:0]       ch_load,
   input  logic [NUM_CH*CNT_W-1:0] ch_load_val,
   input  logic [NUM_CH-1:0]       ch_start,
   input  logic [NUM_CH-1:0]       ch_pause,
   input  logic [NUM_CH-1:0]       ch_periodic,
   output logic [NUM_CH*CNT_W-1:0] ch_count,
   output logic [NUM_CH-1:0]       ch_running,
   output logic [NUM_CH-1:0]       ch_expire
);

   localparam int               DIV      = calc_div(CLK_HZ, TICK_HZ);
   localparam int               PRE_W    = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(DIV - 1);
   localparam logic [CNT_W-1:0] WRAP_MAX = CNT_W'(WRAP - 1);

   if (DIV < 2) begin : g_div_check
      $error("game_timebase: CLK_HZ/TICK_HZ must be at least 2");
   end
   if ((CLK_HZ % TICK_HZ) != 0) begin : g_div_int_check
      $error("game_timebase: CLK_HZ must be an integer multiple of TICK_HZ");
   end
   if ((CNT_W < 1) || (CNT_W > 32)) begin : g_cnt_w_check
      $error("game_timebase: CNT_W must be in 1..32");
   end
   if ((WRAP < 1) || (WRAP > (longint'(1) << CNT_W))) begin : g_wrap_check
      $error("game_timebase: WRAP must be in 1..2**CNT_W");
   end
   if ((NUM_CH < 1) || (NUM_CH > 16)) begin : g_num_ch_check
      $error("game_timebase: NUM_CH must be in 1..16");
   end

   logic [PRE_W-1:0] pre;

   // Prescaler freezes while tick_en is low, so the tick phase is preserved
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pre  <= '0;
         tick <= 1'b0;
      end else if (tick_en) begin
         if (pre == PRE_MAX) begin
            pre  <= '0;
            tick <= 1'b1;
         end else begin
            pre  <= pre + 1'b1;
            tick <= 1'b0;
         end
      end else begin
         tick <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         elapsed <= '0;
      end else if (elapsed_clr) begin
         elapsed <= '0;
      end else if (tick) begin
         elapsed <= (elapsed == WRAP_MAX) ? '0 : elapsed + 1'b1;
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      timer_channel #(
         .CNT_W(CNT_W)
      ) u_channel (
         .clk      (clk),
         .reset    (reset),
         .tick     (tick),
         .load     (ch_load[i]),
         .load_val (ch_load_val[i*CNT_W +: CNT_W]),
         .start    (ch_start[i]),
         .pause    (ch_pause[i]),
         .periodic (ch_periodic[i]),
         .count    (ch_count[i*CNT_W +: CNT_W]),
         .running  (ch_running[i]),
         .expire   (ch_expire[i])
      );
   end

endmodule

// File: tb/tb_game_timebase.sv
// Directed bench for game_timebase with DIV=10, CNT_W=8, WRAP=20, NUM_CH=2.
// Channel behaviour is driven from a vector table; tick cadence, elapsed and reset use hand sequences.
module tb_game_timebase;

   logic        clk = 1'b0;
   logic        reset;
   logic        tick_en;
   logic        elapsed_clr;
   logic        tick;
   logic [7:0]  elapsed;
   logic [1:0]  ch_load;
   logic [15:0] ch_load_val;
   logic [1:0]  ch_start;
   logic [1:0]  ch_pause;
   logic [1:0]  ch_periodic;
   logic [15:0] ch_count;
   logic [1:0]  ch_running;
   logic [1:0]  ch_expire;

   int n_checks = 0;
   int n_fail   = 0;
   int x_cnt [2] = '{0, 0};

   typedef struct {
      logic [1:0] load;
      logic [7:0] val0;
      logic [7:0] val1;
      logic [1:0] start;
      logic [1:0] pause;
      logic [1:0] periodic;
      int         ticks;
      logic [7:0] c0;
      logic [7:0] c1;
      logic [1:0] run;
      int         x0;
      int         x1;
   } vec_t;

   localparam int NVEC = 18;
   vec_t vecs [NVEC];

   game_timebase #(
      .CLK_HZ  (1000),
      .TICK_HZ (100),
      .CNT_W   (8),
      .WRAP    (20),
      .NUM_CH  (2)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .tick_en     (tick_en),
      .elapsed_clr (elapsed_clr),
      .tick        (tick),
      .elapsed     (elapsed),
      .ch_load     (ch_load),
      .ch_load_val (ch_load_val),
      .ch_start    (ch_start),
      .ch_pause    (ch_pause),
      .ch_periodic (ch_periodic),
      .ch_count    (ch_count),
      .ch_running  (ch_running),
      .ch_expire   (ch_expire)
   );

   always #5 clk = ~clk;

   // Every cycle that ch_expire is high adds one, so a stretched pulse shows up as an extra expiry
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (ch_expire[i]) x_cnt[i]++;
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   // Returns just after the edge that raised tick
   task automatic wait_tick();
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 40; k++) begin
         cycle();
         if (tick) begin
            ok = 1'b1;
            break;
         end
      end
      check_output("tick_seen", 32'(ok), 32'd1);
   endtask

   task automatic advance_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         wait_tick();
         cycle();
      end
   endtask

   task automatic apply_stimulus(input vec_t v);
      for (int k = 0; k < 3 && tick; k++) cycle();
      ch_load     = v.load;
      ch_load_val = {v.val1, v.val0};
      ch_start    = v.start;
      ch_pause    = v.pause;
      ch_periodic = v.periodic;
      cycle();
      ch_load  = 2'b00;
      ch_start = 2'b00;
      ch_pause = 2'b00;
   endtask

   initial begin
      int tick_at [3];
      int nt;
      int late_at;
      int off_ticks;
      int xs0;
      int xs1;

      //                load   val0   val1   start  pause  per    tk  c0     c1     run    x0 x1
      vecs[0]  = '{2'b11, 8'd3, 8'd2, 2'b00, 2'b00, 2'b10, 0, 8'd3, 8'd2, 2'b00, 0, 0};
      vecs[1]  = '{2'b00, 8'd0, 8'd0, 2'b11, 2'b00, 2'b10, 0, 8'd3, 8'd2, 2'b11, 0, 0};
      vecs[2]  = '{2'b00, 8'd0, 8'd0, 2'b00, 2'b00, 2'b10, 1, 8'd2, 8'd1, 2'b11, 0, 0};
      vecs[3]  = '{2'b00, 8'd0, 8'd0, 2'b00, 2'b00, 2'b10, 1, 8'd1, 8'd2, 2'b11, 0, 1};
      vecs[4]  = '{2'b00, 8'd0, 8'd0, 2'b00, 2'b00, 2'b10, 1, 8'd0, 8'd1, 2'b10, 1, 0};
      vecs[5]  = '{2'b00, 8'd0, 8'd0, 2'b01, 2'b00, 2'b10, 1, 8'd0, 8'd2, 2'b10, 0, 1};
      vecs[6]  = '{2'b00, 8'd0, 8'd0, 2'b00, 2'b00, 2'b10, 2, 8'd0, 8'd2, 2'b10, 0, 1};
      vecs[7]  = '{2'b11, 8'd5, 8'd0, 2'b00, 2'b00, 2'b00, 0, 8'd5, 8'd0, 2'b00, 0, 0};
      vecs[8]  = '{2'b00, 8'd0, 8'd0, 2'b11, 2'b00, 2'b00, 2, 8'd3, 8'd0, 2'b01, 0, 0};
      vecs[9]  = '{2'b00, 8'd0, 8'd0, 2'b00, 2'b01, 2'b00, 4, 8'd3, 8'd0, 2'b00, 0, 0};
      vecs[10] = '{2'b00, 8'd0, 8'd0, 2'b01, 2'b00, 2'b00, 2, 8'd1, 8'd0, 2'b01, 0, 0};
      vecs[11] = '{2'b00, 8'd0, 8'd0, 2'b00, 2'b00, 2'b00, 1, 8'd0, 8'd0, 2'b00, 1, 0};
      vecs[12] = '{2'b01, 8'd4, 8'd0, 2'b00, 2'b00, 2'b00, 0, 8'd4, 8'd0, 2'b00, 0, 0};
      vecs[13] = '{2'b00, 8'd0, 8'd0, 2'b01, 2'b00, 2'b00, 1, 8'd3, 8'd0, 2'b01, 0, 0};
      vecs[14] = '{2'b00, 8'd0, 8'd0, 2'b01, 2'b01, 2'b00, 2, 8'd3, 8'd0, 2'b00, 0, 0};
      vecs[15] = '{2'b00, 8'd0, 8'd0, 2'b01, 2'b00, 2'b00, 1, 8'd2, 8'd0, 2'b01, 0, 0};
      vecs[16] = '{2'b10, 8'd0, 8'd1, 2'b00, 2'b00, 2'b10, 0, 8'd2, 8'd1, 2'b01, 0, 0};
      vecs[17] = '{2'b00, 8'd0, 8'd0, 2'b10, 2'b00, 2'b10, 3, 8'd0, 8'd1, 2'b10, 1, 3};

      reset       = 1'b0;
      tick_en     = 1'b1;
      elapsed_clr = 1'b0;
      ch_load     = 2'b00;
      ch_load_val = 16'd0;
      ch_start    = 2'b00;
      ch_pause    = 2'b00;
      ch_periodic = 2'b00;

      repeat (5) cycle();
      check_output("reset_tick", 32'(tick), 32'd0);
      check_output("reset_elapsed", 32'(elapsed), 32'd0);
      check_output("reset_count", 32'(ch_count), 32'd0);
      check_output("reset_running", 32'(ch_running), 32'd0);
      check_output("reset_expire", 32'(ch_expire), 32'd0);

      $display("[TB] tick cadence after reset release");
      reset = 1'b1;
      tick_at = '{-1, -1, -1};
      nt = 0;
      for (int k = 1; k <= 35 && nt < 3; k++) begin
         cycle();
         if (tick) begin
            tick_at[nt] = k;
            nt++;
         end
      end
      check_output("first_tick_cycle", 32'(tick_at[0]), 32'd10);
      check_output("second_tick_cycle", 32'(tick_at[1]), 32'd20);
      check_output("third_tick_cycle", 32'(tick_at[2]), 32'd30);

      tick_en = 1'b0;
      off_ticks = 0;
      repeat (5) begin
         cycle();
         if (tick) off_ticks++;
      end
      tick_en = 1'b1;
      check_output("tick_while_disabled", 32'(off_ticks), 32'd0);
      late_at = -1;
      for (int k = 36; k <= 60; k++) begin
         cycle();
         if (tick) begin
            late_at = k;
            break;
         end
      end
      check_output("delayed_tick_cycle", 32'(late_at), 32'd45);
      cycle();
      check_output("tick_one_cycle", 32'(tick), 32'd0);

      $display("[TB] elapsed wrap and clear");
      elapsed_clr = 1'b1;
      cycle();
      elapsed_clr = 1'b0;
      check_output("elapsed_clear", 32'(elapsed), 32'd0);
      advance_ticks(19);
      check_output("elapsed_19", 32'(elapsed), 32'd19);
      advance_ticks(1);
      check_output("elapsed_wrap", 32'(elapsed), 32'd0);
      wait_tick();
      elapsed_clr = 1'b1;
      cycle();
      elapsed_clr = 1'b0;
      check_output("elapsed_clr_beats_tick", 32'(elapsed), 32'd0);
      advance_ticks(1);
      check_output("elapsed_after_clr", 32'(elapsed), 32'd1);

      $display("[TB] channel vector table");
      for (int i = 0; i < NVEC; i++) begin
         xs0 = x_cnt[0];
         xs1 = x_cnt[1];
         apply_stimulus(vecs[i]);
         advance_ticks(vecs[i].ticks);
         settle();
         check_output($sformatf("v%0d_count0", i), 32'(ch_count[7:0]), 32'(vecs[i].c0));
         check_output($sformatf("v%0d_count1", i), 32'(ch_count[15:8]), 32'(vecs[i].c1));
         check_output($sformatf("v%0d_running", i), 32'(ch_running), 32'(vecs[i].run));
         check_output($sformatf("v%0d_expire0", i), 32'(x_cnt[0] - xs0), 32'(vecs[i].x0));
         check_output($sformatf("v%0d_expire1", i), 32'(x_cnt[1] - xs1), 32'(vecs[i].x1));
      end

      $display("[TB] load coincident with tick");
      apply_stimulus('{2'b01, 8'd5, 8'd0, 2'b00, 2'b00, 2'b00, 0, 8'd0, 8'd0, 2'b00, 0, 0});
      apply_stimulus('{2'b00, 8'd0, 8'd0, 2'b01, 2'b00, 2'b00, 0, 8'd0, 8'd0, 2'b00, 0, 0});
      settle();
      check_output("lt_running_before", 32'(ch_running[0]), 32'd1);
      xs0 = x_cnt[0];
      wait_tick();
      ch_load     = 2'b01;
      ch_load_val = {8'd0, 8'd7};
      cycle();
      ch_load = 2'b00;
      settle();
      check_output("lt_count_is_load", 32'(ch_count[7:0]), 32'd7);
      check_output("lt_idle_after_load", 32'(ch_running[0]), 32'd0);
      advance_ticks(1);
      settle();
      check_output("lt_idle_ignores_tick", 32'(ch_count[7:0]), 32'd7);
      check_output("lt_no_expire", 32'(x_cnt[0] - xs0), 32'd0);

      $display("[TB] reset while both channels run");
      apply_stimulus('{2'b11, 8'd6, 8'd6, 2'b00, 2'b00, 2'b00, 0, 8'd0, 8'd0, 2'b00, 0, 0});
      apply_stimulus('{2'b00, 8'd0, 8'd0, 2'b11, 2'b00, 2'b00, 0, 8'd0, 8'd0, 2'b00, 0, 0});
      advance_ticks(2);
      settle();
      check_output("pre_reset_count0", 32'(ch_count[7:0]), 32'd4);
      check_output("pre_reset_count1", 32'(ch_count[15:8]), 32'd4);
      xs0 = x_cnt[0];
      xs1 = x_cnt[1];
      reset = 1'b0;
      #1;
      check_output("async_reset_count", 32'(ch_count), 32'd0);
      check_output("async_reset_running", 32'(ch_running), 32'd0);
      check_output("async_reset_expire", 32'(ch_expire), 32'd0);
      check_output("async_reset_elapsed", 32'(elapsed), 32'd0);
      check_output("async_reset_tick", 32'(tick), 32'd0);
      repeat (25) cycle();
      reset = 1'b1;
      advance_ticks(5);
      settle();
      check_output("post_reset_count", 32'(ch_count), 32'd0);
      check_output("post_reset_running", 32'(ch_running), 32'd0);
      check_output("post_reset_expire0", 32'(x_cnt[0] - xs0), 32'd0);
      check_output("post_reset_expire1", 32'(x_cnt[1] - xs1), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
